ps2_mouse_packet: RTL
=====================

# ps2_mouse_packet

Downstream consumer of the PS/2 mouse receive/transmit front end. Takes received bytes plus the stream-mode and failure flags, assembles standard 3-byte stream-mode movement packets, and checks byte-0 framing. Extracts buttons and 9-bit signed deltas, then maintains a clamped absolute cursor position for the display logic. All outputs are registered and run on the system clock domain.

## Interface
Parameters:
- XMAX, 639, largest legal cursor X (screen width − 1)
- YMAX, 479, largest legal cursor Y
- PW, 10, width of PosX/PosY
- TIMEOUT, 100000, maximum clocks allowed between bytes of one packet (2 ms at 50 MHz)

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  reset; synchronous, active-high.
- STREAM  in  1  mouse is in stream mode; decoding is enabled only while high.
- FAIL  in  1  receive-side error flag (parity/frame/handshake failure).
- DatoRec  in  8  received byte.
- DatoValid  in  1  one-cycle strobe; DatoRec is valid this cycle.
- Buttons  out  3  {middle,right,left} from the last good packet.
- DX, DY  out  9 each  signed deltas {sign, byte}, raw, from the last good packet.
- OvfX, OvfY  out  1 each  overflow bits from the last good packet.
- PosX, PosY  out  PW each  clamped cursor position; screen Y grows downward.
- PktValid  out  1  one-cycle pulse when a packet completes and all outputs update.
- SyncErr  out  1  one-cycle pulse when a byte-0 candidate is rejected.

## Operation
- FSM states: BYTE0 → BYTE1 → BYTE2 → BYTE0. Advances only on DatoValid while STREAM=1 and FAIL=0.
- BYTE0 accept: DatoRec[3]=1 is required.
  - If accepted, latch the byte as the header (buttons [2:0], X sign [4], Y sign [5], X ovf [6], Y ovf [7]).
  - If DatoRec[3]=0, drop the byte, pulse SyncErr, and stay in BYTE0. This is how resync is achieved.
- BYTE1: latch the X magnitude. BYTE2: latch the Y magnitude and go to BYTE0.
- Commit happens in the cycle after the BYTE2 strobe:
  - PktValid=1.
  - Buttons, DX, DY, OvfX and OvfY load.
  - Position updates.
- Position arithmetic uses signed PW+2 bits.
  - nx = PosX + DX, clamped to [0, XMAX].
  - ny = PosY − DY, clamped to [0, YMAX].
  - If OvfX=1 the X axis is treated as delta 0; the same rule applies to Y. DX/DY outputs still show the raw values.
- Abort rules: return to BYTE0, discard any partial packet, and emit no PktValid when any of the following holds:
  - FAIL=1 (in any state)
  - STREAM=0
  - the inter-byte counter reaches TIMEOUT while in BYTE1 or BYTE2
- Inter-byte counter: clears on each accepted byte, counts while in BYTE1/BYTE2, and holds at 0 in BYTE0.
- Simultaneous events:
  - FAIL with DatoValid: FAIL wins and the byte is discarded.
  - Byte arriving in the cycle the counter hits TIMEOUT: the byte is accepted normally.
  - STREAM falling in the commit cycle: the commit still completes.

## Timing
- Reset values:
  - state BYTE0, counter 0
  - Buttons 0, DX 0, DY 0, OvfX/OvfY 0
  - PosX = XMAX>>1 (319), PosY = YMAX>>1 (239)
  - PktValid 0, SyncErr 0
- Latency: PktValid and all updated outputs appear exactly one clock after the BYTE2 DatoValid.
- SyncErr appears one clock after the offending strobe.
- Outputs hold between packets. Consecutive packets may arrive back-to-back with no idle time beyond one clock per byte.
- RST mid-packet: full reset on the next edge, and the partial packet is lost.

## Structure
- Shared package `ps2_mouse_pkg` holds:
  - the state enum (BYTE0/BYTE1/BYTE2)
  - header bit-index constants (BTN_LSB=0, SYNC_BIT=3, XSIGN=4, YSIGN=5, XOVF=6, YOVF=7)
  - PKT_BYTES=3
- Sub-module `ps2_axis_accum`: parameterized saturating accumulator (MAX, PW, NEG selects subtract). It is instantiated twice, once for X and once for Y, with an overflow-gate input.

## Test plan
- Reset, then bytes 0x09, 0x05, 0x03 → PktValid one cycle later; Buttons=001, DX=+5, DY=+3, PosX=324, PosY=236.
- Header 0x18 (X sign), bytes 0xF6, 0x00 → DX=−10; PosX decreases by 10. Repeat from PosX=5 → PosX clamps to 0.
- Byte 0x00 while in BYTE0 → SyncErr pulse, no state change; then a valid packet → normal commit.
- Bytes 0x08, 0x10, then 100001 idle clocks, then 0x08, 0x01, 0x01 → first packet dropped; second commits with DX=+1.
- FAIL asserted together with the BYTE1 strobe → abort; the next three bytes form a fresh packet. Separately, header 0x48 (OvfX) with DX=0x20 → PosX unchanged and DX output = +32.
- RST asserted after BYTE1 → outputs return to reset values with no PktValid. STREAM low during a packet → no commit.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared types and header layout for the PS/2 mouse packet decoder.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2
    } pkt_state_t;

    localparam int BTN_LSB   = 0;
    localparam int SYNC_BIT  = 3;
    localparam int XSIGN     = 4;
    localparam int YSIGN     = 5;
    localparam int XOVF      = 6;
    localparam int YOVF      = 7;
    localparam int PKT_BYTES = 3;

    typedef struct packed {
        logic [2:0] btn;
        logic [8:0] dx;
        logic [8:0] dy;
        logic       ovfx;
        logic       ovfy;
    } pkt_t;

    function automatic pkt_t decode(
        input logic [7:0] h,
        input logic [7:0] xm,
        input logic [7:0] ym
    );
        pkt_t p;
        p.btn  = h[BTN_LSB +: 3];
        p.dx   = {h[XSIGN], xm};
        p.dy   = {h[YSIGN], ym};
        p.ovfx = h[XOVF];
        p.ovfy = h[YOVF];
        return p;
    endfunction

endpackage

// File: rtl/ps2_axis_accum.sv
// Saturating cursor accumulator for one axis; NEG subtracts the delta.
module ps2_axis_accum #(
    parameter int MAX = 639,
    parameter int PW  = 10,
    parameter bit NEG = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          gate,
    input  logic [8:0]    delta,
    output logic [PW-1:0] pos
);

    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] SMAX = SW'(MAX);

    logic signed [SW-1:0] cur;
    logic signed [SW-1:0] d;
    logic signed [SW-1:0] sum;

    always_comb begin
        cur = $signed({2'b00, pos});
        // An overflowed axis contributes no motion.
        d   = gate ? '0 : $signed({{(SW-9){delta[8]}}, delta});
        sum = NEG ? (cur - d) : (cur + d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= PW'(MAX >> 1);
        end else if (load) begin
            if (sum[SW-1])
                pos <= '0;
            else if (sum > SMAX)
                pos <= PW'(MAX);
            else
                pos <= sum[PW-1:0];
        end
    end

endmodule

// File: rtl/ps2_mouse_packet.sv
// Assembles 3-byte stream-mode mouse packets and tracks a clamped cursor.
module ps2_mouse_packet
    import ps2_mouse_pkg::*;
#(
    parameter int XMAX    = 639,
    parameter int YMAX    = 479,
    parameter int PW      = 10,
    parameter int TIMEOUT = 100000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          STREAM,
    input  logic          FAIL,
    input  logic [7:0]    DatoRec,
    input  logic          DatoValid,
    output logic [2:0]    Buttons,
    output logic [8:0]    DX,
    output logic [8:0]    DY,
    output logic          OvfX,
    output logic          OvfY,
    output logic [PW-1:0] PosX,
    output logic [PW-1:0] PosY,
    output logic          PktValid,
    output logic          SyncErr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    pkt_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    hdr, xmag;
    logic          timeout, commit, sync_bad, take;
    pkt_t          pkt;

    always_comb begin
        take     = DatoValid && STREAM && !FAIL;
        timeout  = (cnt == CW'(TIMEOUT));
        state_n  = state;
        cnt_n    = '0;
        commit   = 1'b0;
        sync_bad = 1'b0;
        if (!STREAM || FAIL) begin
            state_n = BYTE0;
        end else begin
            case (state)
                BYTE0: begin
                    if (DatoValid) begin
                        if (DatoRec[SYNC_BIT])
                            state_n = BYTE1;
                        else
                            sync_bad = 1'b1;
                    end
                end
                BYTE1: begin
                    if (DatoValid)
                        state_n = BYTE2;
                    else if (timeout)
                        state_n = BYTE0;
                    else
                        cnt_n = cnt + CW'(1);
                end
                BYTE2: begin
                    // A byte landing on the timeout cycle still counts.
                    if (DatoValid) begin
                        state_n = BYTE0;
                        commit  = 1'b1;
                    end else if (timeout) begin
                        state_n = BYTE0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: state_n = BYTE0;
            endcase
        end
    end

    assign pkt = decode(hdr, xmag, DatoRec);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= BYTE0;
            cnt      <= '0;
            hdr      <= '0;
            xmag     <= '0;
            Buttons  <= '0;
            DX       <= '0;
            DY       <= '0;
            OvfX     <= 1'b0;
            OvfY     <= 1'b0;
            PktValid <= 1'b0;
            SyncErr  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            PktValid <= commit;
            SyncErr  <= sync_bad;
            if (take && state == BYTE0 && DatoRec[SYNC_BIT])
                hdr <= DatoRec;
            if (take && state == BYTE1)
                xmag <= DatoRec;
            if (commit) begin
                Buttons <= pkt.btn;
                DX      <= pkt.dx;
                DY      <= pkt.dy;
                OvfX    <= pkt.ovfx;
                OvfY    <= pkt.ovfy;
            end
        end
    end

    ps2_axis_accum #(.MAX(XMAX), .PW(PW), .NEG(1'b0)) u_x (
        .clk   (CLK),
        .rst   (RST),
        .load  (commit),
        .gate  (pkt.ovfx),
        .delta (pkt.dx),
        .pos   (PosX)
    );

    // Screen Y grows downward, so a positive mouse DY moves the cursor up.
    ps2_axis_accum #(.MAX(YMAX), .PW(PW), .NEG(1'b1)) u_y (
        .clk   (CLK),
        .rst   (RST),
        .load  (commit),
        .gate  (pkt.ovfy),
        .delta (pkt.dy),
        .pos   (PosY)
    );

endmodule
